// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a 16x8 RAM between the CPU and a debug port.
// The debug port stalls the CPU (CPU_HALT), waits HALT_WAIT cycles, then
// owns the RAM for a burst of beats before handing it back.
// Optional feature: define RAM_ARB_AUTOINC_EN to have burst beats after the
// first one take their address from an internal incrementing counter.
module ram_arbiter #(
    parameter int HALT_WAIT = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] CPU_ADDR,
    input  logic [7:0] CPU_DIN,
    input  logic       CPU_RI,
    output logic [7:0] CPU_DOUT,
    output logic       CPU_HALT,
    input  logic       DBG_REQ,
    input  logic       DBG_WE,
    input  logic [3:0] DBG_ADDR,
    input  logic [7:0] DBG_DIN,
    input  logic       DBG_LAST,
    output logic       DBG_ACK,
    output logic [7:0] DBG_DOUT,
    output logic [3:0] RAM_ADDR,
    output logic [7:0] RAM_DIN,
    output logic       RAM_RI,
    input  logic [7:0] RAM_DOUT
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HALT    = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Counter load value: HALT lasts HALT_WAIT cycles, counting down to zero.
    localparam logic [3:0] WAIT_LOAD = 4'(HALT_WAIT - 1);

    state_t     state_reg, state_next;
    logic [3:0] wait_reg, wait_next;
    logic       halt_reg;
    logic       grant;
    logic       dbg_ack;
    logic [3:0] dbg_addr_eff;

    // State, wait counter and the registered CPU stall flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
            wait_reg  <= 4'd0;
            halt_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            halt_reg  <= (state_next != IDLE);
        end
    end

    // Next-state logic; a dropped request in HALT takes priority over the grant.
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        case (state_reg)
            IDLE: begin
                if (DBG_REQ) begin
                    state_next = HALT;
                    wait_next  = WAIT_LOAD;
                end
            end
            HALT: begin
                if (!DBG_REQ) begin
                    state_next = RELEASE;
                end else if (wait_reg == 4'd0) begin
                    state_next = GRANT;
                end else begin
                    wait_next = wait_reg - 4'd1;
                end
            end
            GRANT: begin
                if (!DBG_REQ || DBG_LAST) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign grant   = (state_reg == GRANT);
    assign dbg_ack = grant && DBG_REQ;

`ifdef RAM_ARB_AUTOINC_EN
    logic [3:0] addr_reg;
    logic       first_reg;

    // Burst address counter: the first GRANT cycle takes DBG_ADDR, later beats follow the counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            addr_reg  <= 4'd0;
            first_reg <= 1'b1;
        end else begin
            first_reg <= (state_reg != GRANT);
            if (dbg_ack) begin
                addr_reg <= dbg_addr_eff + 4'd1;
            end
        end
    end

    assign dbg_addr_eff = first_reg ? DBG_ADDR : addr_reg;
`else
    assign dbg_addr_eff = DBG_ADDR;
`endif

    // RAM port mux; reset masks the strobe so an in-flight write is dropped.
    always_comb begin
        RAM_ADDR = CPU_ADDR;
        RAM_DIN  = CPU_DIN;
        RAM_RI   = CPU_RI & ~RESET;
        if (grant) begin
            RAM_ADDR = dbg_addr_eff;
            RAM_DIN  = DBG_DIN;
            RAM_RI   = DBG_WE & dbg_ack & ~RESET;
        end
    end

    assign CPU_DOUT = grant ? 8'h00 : RAM_DOUT;
    assign DBG_DOUT = dbg_ack ? RAM_DOUT : 8'h00;
    assign DBG_ACK  = dbg_ack;
    assign CPU_HALT = halt_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: two instances (HALT_WAIT=1 and HALT_WAIT=3)
// share stimulus, each with its own 16x8 RAM model.
module tb_ram_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_din;
    logic       cpu_ri;
    logic       dbg_req, dbg_we, dbg_last;
    logic [3:0] dbg_addr;
    logic [7:0] dbg_din;

    logic [7:0] cpu_dout_a, dbg_dout_a, ram_din_a, ram_dout_a;
    logic       cpu_halt_a, dbg_ack_a, ram_ri_a;
    logic [3:0] ram_addr_a;
    logic [7:0] cpu_dout_b, dbg_dout_b, ram_din_b, ram_dout_b;
    logic       cpu_halt_b, dbg_ack_b, ram_ri_b;
    logic [3:0] ram_addr_b;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] snap_b [16];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ram_arbiter #(.HALT_WAIT(1)) dut_a (
        .CLK(CLK), .RESET(RESET),
        .CPU_ADDR(cpu_addr), .CPU_DIN(cpu_din), .CPU_RI(cpu_ri),
        .CPU_DOUT(cpu_dout_a), .CPU_HALT(cpu_halt_a),
        .DBG_REQ(dbg_req), .DBG_WE(dbg_we), .DBG_ADDR(dbg_addr),
        .DBG_DIN(dbg_din), .DBG_LAST(dbg_last),
        .DBG_ACK(dbg_ack_a), .DBG_DOUT(dbg_dout_a),
        .RAM_ADDR(ram_addr_a), .RAM_DIN(ram_din_a), .RAM_RI(ram_ri_a),
        .RAM_DOUT(ram_dout_a)
    );

    ram_arbiter #(.HALT_WAIT(3)) dut_b (
        .CLK(CLK), .RESET(RESET),
        .CPU_ADDR(cpu_addr), .CPU_DIN(cpu_din), .CPU_RI(cpu_ri),
        .CPU_DOUT(cpu_dout_b), .CPU_HALT(cpu_halt_b),
        .DBG_REQ(dbg_req), .DBG_WE(dbg_we), .DBG_ADDR(dbg_addr),
        .DBG_DIN(dbg_din), .DBG_LAST(dbg_last),
        .DBG_ACK(dbg_ack_b), .DBG_DOUT(dbg_dout_b),
        .RAM_ADDR(ram_addr_b), .RAM_DIN(ram_din_b), .RAM_RI(ram_ri_b),
        .RAM_DOUT(ram_dout_b)
    );

    // RAM models: synchronous write, combinational read that returns 0 while writing.
    assign ram_dout_a = ram_ri_a ? 8'h00 : mem_a[ram_addr_a];
    assign ram_dout_b = ram_ri_b ? 8'h00 : mem_b[ram_addr_b];

    always @(posedge CLK) begin
        if (ram_ri_a) mem_a[ram_addr_a] <= ram_din_a;
        if (ram_ri_b) mem_b[ram_addr_b] <= ram_din_b;
    end

    typedef struct packed {
        logic       req;
        logic       we;
        logic [3:0] addr;
        logic [7:0] din;
        logic       last;
        logic       exp_halt;
        logic       exp_ack;
        logic [7:0] exp_ddout;
        logic [7:0] exp_cdout;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic req, input logic we, input logic [3:0] addr,
                                input logic [7:0] din, input logic last,
                                input logic halt, input logic ack,
                                input logic [7:0] ddout, input logic [7:0] cdout);
        vec_t v;
        v.req = req; v.we = we; v.addr = addr; v.din = din; v.last = last;
        v.exp_halt = halt; v.exp_ack = ack; v.exp_ddout = ddout; v.exp_cdout = cdout;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic req, input logic we, input logic [3:0] a,
                       input logic [7:0] d, input logic last);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_din = d; dbg_last = last;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Hard time limit in case the design never lets the bench progress.
    initial begin
        #500000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic same;
        logic [3:0] a2, a3;

        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        RESET = 1'b1;
        cpu_addr = 4'h3; cpu_din = 8'h00; cpu_ri = 1'b0;
        drv(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);

        // Cycle table, cpu_addr fixed at 3 so CPU_DOUT tracks RAM[3].
        vecs[0]  = mk(1, 1, 4'h3, 8'hA5, 1, 0, 0, 8'h00, 8'h00); // IDLE, req seen
        vecs[1]  = mk(1, 1, 4'h3, 8'hA5, 1, 1, 0, 8'h00, 8'h00); // HALT
        vecs[2]  = mk(1, 1, 4'h3, 8'hA5, 1, 1, 1, 8'h00, 8'h00); // GRANT write A5
        vecs[3]  = mk(0, 0, 4'h0, 8'h00, 0, 1, 0, 8'h00, 8'hA5); // RELEASE
        vecs[4]  = mk(0, 0, 4'h0, 8'h00, 0, 0, 0, 8'h00, 8'hA5); // IDLE
        vecs[5]  = mk(1, 0, 4'h3, 8'h00, 1, 0, 0, 8'h00, 8'hA5); // IDLE, read req
        vecs[6]  = mk(1, 0, 4'h3, 8'h00, 1, 1, 0, 8'h00, 8'hA5); // HALT
        vecs[7]  = mk(1, 0, 4'h3, 8'h00, 1, 1, 1, 8'hA5, 8'h00); // GRANT read
        vecs[8]  = mk(1, 0, 4'h3, 8'h00, 1, 1, 0, 8'h00, 8'hA5); // RELEASE, req held
        vecs[9]  = mk(1, 0, 4'h3, 8'h00, 1, 0, 0, 8'h00, 8'hA5); // IDLE before re-halt
        vecs[10] = mk(1, 0, 4'h3, 8'h00, 1, 1, 0, 8'h00, 8'hA5); // HALT
        vecs[11] = mk(1, 0, 4'h3, 8'h00, 1, 1, 1, 8'hA5, 8'h00); // GRANT read
        vecs[12] = mk(0, 0, 4'h0, 8'h00, 0, 1, 0, 8'h00, 8'hA5); // RELEASE
        vecs[13] = mk(0, 0, 4'h0, 8'h00, 0, 0, 0, 8'h00, 8'hA5); // IDLE
        vecs[14] = mk(1, 0, 4'h3, 8'h00, 0, 0, 0, 8'h00, 8'hA5); // IDLE, req
        vecs[15] = mk(0, 0, 4'h3, 8'h00, 0, 1, 0, 8'h00, 8'hA5); // HALT, req dropped
        vecs[16] = mk(0, 0, 4'h0, 8'h00, 0, 1, 0, 8'h00, 8'hA5); // RELEASE
        vecs[17] = mk(0, 0, 4'h0, 8'h00, 0, 0, 0, 8'h00, 8'hA5); // IDLE

        // Reset state while reset is held.
        #2;
        chk1("reset_halt", cpu_halt_a, 1'b0);
        chk1("reset_ack", dbg_ack_a, 1'b0);
        chk1("reset_ram_ri", ram_ri_a, 1'b0);
        tick();
        RESET = 1'b0;

        // Table-driven cycles on the HALT_WAIT=1 instance.
        for (int i = 0; i < 18; i++) begin
            tick();
            drv(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].last);
            @(negedge CLK);
            $display("vec %0d req=%b we=%b addr=%h din=%h last=%b halt=%b ack=%b ddout=%h cdout=%h",
                     i, vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].last,
                     cpu_halt_a, dbg_ack_a, dbg_dout_a, cpu_dout_a);
            chk1($sformatf("vec%0d_halt", i), cpu_halt_a, vecs[i].exp_halt);
            chk1($sformatf("vec%0d_ack", i), dbg_ack_a, vecs[i].exp_ack);
            chk8($sformatf("vec%0d_dbg_dout", i), dbg_dout_a, vecs[i].exp_ddout);
            chk8($sformatf("vec%0d_cpu_dout", i), cpu_dout_a, vecs[i].exp_cdout);
        end
        chk8("ram3_after_write", mem_a[3], 8'hA5);

        // CPU write lands during HALT, is ignored during GRANT.
        tick(); drv(1, 0, 4'h0, 8'h00, 1);                       // IDLE
        tick(); cpu_ri = 1; cpu_addr = 4'h5; cpu_din = 8'h5A;     // HALT
        @(negedge CLK);
        chk1("halt_cpu_write_ri", ram_ri_a, 1'b1);
        tick(); cpu_ri = 1; cpu_addr = 4'h6; cpu_din = 8'hFF;     // GRANT
        @(negedge CLK);
        chk1("grant_ack", dbg_ack_a, 1'b1);
        chk1("grant_cpu_ri_ignored", ram_ri_a, 1'b0);
        tick(); cpu_ri = 0; cpu_addr = 4'h3; drv(0, 0, 4'h0, 8'h00, 0); // RELEASE
        @(negedge CLK);
        chk8("ram5_cpu_halt_write", mem_a[5], 8'h5A);
        chk8("ram6_unchanged", mem_a[6], 8'h00);
        $display("seq cpu_ri halt/grant ram5=%h ram6=%h", mem_a[5], mem_a[6]);
        tick();                                                  // IDLE

        // Three-beat write burst wrapping 15 -> 0.
`ifdef RAM_ARB_AUTOINC_EN
        a2 = 4'h7; a3 = 4'h7;
`else
        a2 = 4'hF; a3 = 4'h0;
`endif
        tick(); drv(1, 1, 4'hE, 8'h11, 0);                       // IDLE
        tick();                                                  // HALT
        tick();                                                  // GRANT beat 1
        @(negedge CLK);
        chk8("burst_beat1_addr", {4'h0, ram_addr_a}, 8'h0E);
        tick(); drv(1, 1, a2, 8'h22, 0);
        @(negedge CLK);
        chk8("burst_beat2_addr", {4'h0, ram_addr_a}, 8'h0F);
        tick(); drv(1, 1, a3, 8'h33, 1);
        @(negedge CLK);
        chk8("burst_beat3_addr", {4'h0, ram_addr_a}, 8'h00);
        tick(); drv(0, 0, 4'h0, 8'h00, 0);                       // RELEASE
        @(negedge CLK);
        chk8("burst_ramE", mem_a[14], 8'h11);
        chk8("burst_ramF", mem_a[15], 8'h22);
        chk8("burst_ram0", mem_a[0], 8'h33);
        chk8("burst_ram7", mem_a[7], 8'h00);
        $display("seq burst E=%h F=%h 0=%h", mem_a[14], mem_a[15], mem_a[0]);
        tick();                                                  // IDLE

        // HALT_WAIT=3 instance: request dropped in the second HALT cycle.
        tick(); RESET = 1'b1;
        tick(); RESET = 1'b0;
        for (int i = 0; i < 16; i++) snap_b[i] = mem_b[i];
        tick(); drv(1, 0, 4'h2, 8'h00, 1);                       // IDLE
        @(negedge CLK);
        chk1("drop_idle_halt", cpu_halt_b, 1'b0);
        tick();                                                  // HALT 1
        @(negedge CLK);
        chk1("drop_h1_halt", cpu_halt_b, 1'b1);
        chk1("drop_h1_ack", dbg_ack_b, 1'b0);
        tick(); drv(0, 0, 4'h0, 8'h00, 0);                       // HALT 2, dropped
        @(negedge CLK);
        chk1("drop_h2_ack", dbg_ack_b, 1'b0);
        tick();                                                  // RELEASE
        @(negedge CLK);
        chk1("drop_rel_halt", cpu_halt_b, 1'b1);
        chk1("drop_rel_ack", dbg_ack_b, 1'b0);
        tick();                                                  // IDLE
        @(negedge CLK);
        chk1("drop_idle2_halt", cpu_halt_b, 1'b0);
        same = 1'b1;
        for (int i = 0; i < 16; i++) if (mem_b[i] !== snap_b[i]) same = 1'b0;
        chk1("drop_ram_unchanged", same, 1'b1);
        $display("seq halt_wait3 drop halt=%b", cpu_halt_b);

        // HALT_WAIT=3 latency: first ack in the fourth cycle after the request cycle.
        tick(); drv(1, 0, 4'h2, 8'h00, 1);                       // IDLE
        n = 0;
        do begin
            tick();
            n++;
            @(negedge CLK);
        end while (!dbg_ack_b && n < 20);
        chk8("latency_hw3_cycles", 8'(n), 8'd4);
        $display("seq halt_wait3 latency cycles=%0d", n);
        tick(); drv(0, 0, 4'h0, 8'h00, 0);                       // RELEASE
        tick();                                                  // IDLE

        // Reset in the middle of a write burst.
        tick(); drv(1, 1, 4'h9, 8'hC3, 0);                       // IDLE
        tick();                                                  // HALT
        tick();                                                  // GRANT beat 1
        @(negedge CLK);
        chk1("rst_burst_ack", dbg_ack_a, 1'b1);
        tick(); drv(1, 1, 4'hA, 8'h77, 0);                       // GRANT beat 2
        @(negedge CLK);
        chk1("rst_burst_ri_before", ram_ri_a, 1'b1);
        #1 RESET = 1'b1;
        #1;
        chk1("rst_halt_low", cpu_halt_a, 1'b0);
        chk1("rst_ack_low", dbg_ack_a, 1'b0);
        chk1("rst_ram_ri_low", ram_ri_a, 1'b0);
        tick(); RESET = 1'b0; drv(0, 0, 4'h0, 8'h00, 0);
        @(negedge CLK);
        chk1("rst_after_halt", cpu_halt_a, 1'b0);
        chk8("rst_ram9", mem_a[9], 8'hC3);
        chk8("rst_ramA_not_written", mem_a[10], 8'h00);
        tick();
        @(negedge CLK);
        chk1("rst_idle_halt", cpu_halt_a, 1'b0);
        chk1("rst_idle_ack", dbg_ack_a, 1'b0);
        $display("seq reset mid-burst ram9=%h ramA=%h", mem_a[9], mem_a[10]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter HALT_WAIT, default 1, meaning: cycles CPU_HALT is held before the first debug grant; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 CPU_ADDR  input  4  CPU RAM address.
REQ-005 CPU_DIN  input  8  CPU write data.
REQ-006 CPU_RI  input  1  CPU RAM-in (write) strobe.
REQ-007 CPU_DOUT  output  8  RAM read data returned to CPU.
REQ-008 CPU_HALT  output  1  registered stall request to the CPU sequencer.
REQ-009 DBG_REQ  input  1  debug port access request, level.
REQ-010 DBG_WE  input  1  debug beat is a write (1) or read (0).
REQ-011 DBG_ADDR  input  4  debug address.
REQ-012 DBG_DIN  input  8  debug write data.
REQ-013 DBG_LAST  input  1  current debug beat is the last of the burst.
REQ-014 DBG_ACK  output  1  beat accepted this cycle.
REQ-015 DBG_DOUT  output  8  debug read data, valid while DBG_ACK=1 and DBG_WE=0.
REQ-016 RAM_ADDR  output  4  to 16x8 RAM address.
REQ-017 RAM_DIN  output  8  to RAM write data.
REQ-018 RAM_RI  output  1  to RAM write strobe.
REQ-019 RAM_DOUT  input  8  from RAM; combinational read, reads 0 while RAM_RI=1.

Function
REQ-020 States: IDLE, HALT, GRANT, RELEASE; CPU_HALT = 1 in every state except IDLE, driven from a register.
REQ-021 IDLE: DBG_REQ=1 at an edge -> HALT, wait counter loaded with HALT_WAIT-1.
REQ-022 HALT: counter decrements each cycle; at 0 -> GRANT; DBG_REQ=0 in HALT -> RELEASE, no beat performed.
REQ-023 GRANT: DBG_ACK = DBG_REQ (combinational); one beat per cycle with DBG_ACK=1.
REQ-024 Beat with DBG_LAST=1, or DBG_REQ=0 in GRANT -> RELEASE; otherwise remain in GRANT.
REQ-025 RELEASE: lasts exactly one cycle -> IDLE; a DBG_REQ held high re-enters HALT only from IDLE.
REQ-026 Mux: GRANT drives RAM from the debug port (RAM_RI = DBG_WE & DBG_ACK); all other states drive RAM from the CPU port.
REQ-027 CPU_DOUT = RAM_DOUT when the CPU owns the RAM, else 8'h00; DBG_DOUT = RAM_DOUT while DBG_ACK=1, else 8'h00.
REQ-028 Latency: DBG_REQ first sampled high at edge k -> CPU_HALT=1 from cycle k+1, first DBG_ACK in cycle k+1+HALT_WAIT.
REQ-029 CPU_RI during HALT still writes (CPU completing its microstep); CPU_RI during GRANT is ignored.
REQ-030 Addresses are 4-bit modular; no out-of-range condition exists.

Reset
REQ-031 RESET=1 forces, asynchronously: state IDLE, CPU_HALT=0, DBG_ACK=0, wait counter 0, address counter 0; RAM contents untouched.
REQ-032 RESET during GRANT aborts the burst; RAM_RI drops in the same cycle; a write in flight at that cycle is not performed.

Configuration
REQ-033 Macro RAM_ARB_AUTOINC_EN defined: first beat of a burst uses DBG_ADDR and stores DBG_ADDR+1; later beats use the stored counter, incrementing per beat, wrapping 15->0; DBG_ADDR ignored after the first beat.
REQ-034 RAM_ARB_AUTOINC_EN undefined: every beat uses DBG_ADDR directly; no address counter is implemented.

Verification
REQ-035 HALT_WAIT=1, DBG_REQ rises after edge 0, WE=1, ADDR=4'h3, DIN=8'hA5, LAST=1 -> CPU_HALT high cycle 1, DBG_ACK cycle 2, RAM[3]=8'hA5, IDLE by cycle 4.
REQ-036 Read beat ADDR=4'h3 after REQ-035 -> DBG_DOUT=8'hA5 with DBG_ACK; CPU_DOUT=8'h00 that cycle.
REQ-037 AUTOINC_EN, 3-beat write burst start ADDR=4'hE, DIN 8'h11/8'h22/8'h33 -> RAM[E]=11, RAM[F]=22, RAM[0]=33.
REQ-038 HALT_WAIT=3, DBG_REQ dropped in second HALT cycle -> no DBG_ACK, one RELEASE cycle, CPU_HALT low next cycle, RAM unchanged.
REQ-039 CPU_RI=1 ADDR=4'h5 DIN=8'h5A in HALT cycle, then CPU_RI=1 ADDR=4'h6 DIN=8'hFF in GRANT -> RAM[5]=8'h5A, RAM[6] unchanged.
REQ-040 RESET pulse mid-burst with DBG_WE=1 -> CPU_HALT, DBG_ACK, RAM_RI low immediately; state IDLE after release.
